// File: rtl/turbosound_bus.sv
// rtl/turbosound_bus.sv - host bus decoder and write queue for up to four PSG/FM chips
// Host writes are synchronized, decoded into chip register/data writes, queued, and drained one per CE.
module turbosound_bus #(
  parameter int NCHIPS     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CE,
  input  logic                  BDIR,
  input  logic                  BC,
  input  logic [7:0]            DI,
  output logic [7:0]            DO,
  input  logic [8*NCHIPS-1:0]   DI_RD,
  output logic                  RD_A0,
  output logic                  WR_STB,
  output logic [NCHIPS-1:0]     WR_CS,
  output logic                  WR_A0,
  output logic [7:0]            WR_D,
  output logic [NCHIPS-1:0]     FM_ENA,
  output logic [1:0]            CUR_CHIP,
  output logic                  BUSY,
  output logic                  OVF
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic       bdir_s1, bdir_s2, bdir_q;
  logic       bc_s1, bc_s2;
  logic [7:0] di_s1, di_s2;

  logic [1:0]        chip;
  logic              bank;
  logic              stat_sel;
  logic [NCHIPS-1:0] fm_ena;
  logic              acc;
  logic              ovf;

  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic        fire, is_sel, is_bank, sel_ok, fm_cur, reg_acc;
  logic        push, pop, full, do_write;
  logic [1:0]  sel_chip;
  logic [10:0] head;
  logic [NCHIPS-1:0] cs_next;

  // Synchronizer and edge detector run regardless of reset so BDIR held high
  // across reset release is already "seen" and does not fire.
  always_ff @(posedge CLK) begin
    bdir_s1 <= BDIR;
    bdir_s2 <= bdir_s1;
    bdir_q  <= bdir_s2;
    bc_s1   <= BC;
    bc_s2   <= bc_s1;
    di_s1   <= DI;
    di_s2   <= di_s1;
  end

  always_comb begin
    fire     = bdir_s2 & ~bdir_q;
    is_sel   = bc_s2 && (di_s2[7:3] == 5'b11111);
    is_bank  = bc_s2 && (di_s2[7:2] == 6'b111100);
    sel_chip = {bank, ~di_s2[0]};
    sel_ok   = (32'(sel_chip) < NCHIPS);
    fm_cur   = 1'b0;
    for (int i = 0; i < NCHIPS; i++) begin
      if (chip == 2'(i)) fm_cur = fm_ena[i];
    end
    reg_acc  = (di_s2[7:4] == 4'd0) | fm_cur;
    push     = fire && ((bc_s2 && !is_sel && !is_bank && reg_acc) || (!bc_s2 && acc));
    pop      = CE && (count != '0);
    full     = (count == CW'(FIFO_DEPTH));
    do_write = push && (!full || pop);
    head     = mem[rptr];
    cs_next  = '0;
    for (int i = 0; i < NCHIPS; i++) begin
      if (head[10:9] == 2'(i)) cs_next[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_write) mem[wptr] <= {chip, ~bc_s2, di_s2};
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      chip     <= 2'd0;
      bank     <= 1'b0;
      stat_sel <= 1'b1;
      fm_ena   <= '0;
      acc      <= 1'b0;
      ovf      <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      WR_STB   <= 1'b0;
      WR_CS    <= '0;
      WR_A0    <= 1'b0;
      WR_D     <= 8'd0;
    end else begin
      if (fire) begin
        if (is_sel) begin
          if (sel_ok) begin
            chip     <= sel_chip;
            stat_sel <= di_s2[1];
            for (int i = 0; i < NCHIPS; i++) begin
              if (sel_chip == 2'(i)) fm_ena[i] <= ~di_s2[2];
            end
            acc <= 1'b0;
          end
        end else if (is_bank) begin
          if (NCHIPS > 2) bank <= di_s2[0];
          acc <= 1'b0;
        end else if (bc_s2) begin
          acc <= reg_acc;
        end
      end

      if (do_write) wptr <= wptr + AW'(1);
      if (push && full && !pop) ovf <= 1'b1;

      if (pop) begin
        rptr   <= rptr + AW'(1);
        WR_STB <= 1'b1;
        WR_CS  <= cs_next;
        WR_A0  <= head[8];
        WR_D   <= head[7:0];
      end else begin
        WR_STB <= 1'b0;
      end

      case ({do_write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    DO = 8'd0;
    for (int i = 0; i < NCHIPS; i++) begin
      if (chip == 2'(i)) DO = DI_RD[8*i +: 8];
    end
  end

  assign RD_A0    = stat_sel;
  assign FM_ENA   = fm_ena;
  assign CUR_CHIP = chip;
  assign BUSY     = (count != '0);
  assign OVF      = ovf;

endmodule

// File: tb/tb_turbosound_bus.sv
// tb/tb_turbosound_bus.sv - scoreboard bench for turbosound_bus
// Host writes feed a behavioural model that queues expected chip writes; a monitor checks strobes.
module tb_turbosound_bus;

  localparam int NCHIPS = 2;
  localparam int DEPTH  = 8;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CE = 1'b1;
  logic        BDIR = 1'b0;
  logic        BC = 1'b0;
  logic [7:0]  DI = 8'd0;
  logic [7:0]  DO;
  logic [15:0] DI_RD = 16'd0;
  logic        RD_A0, WR_STB, WR_A0, BUSY, OVF;
  logic [1:0]  WR_CS, FM_ENA, CUR_CHIP;
  logic [7:0]  WR_D;

  turbosound_bus #(.NCHIPS(NCHIPS), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .BDIR(BDIR), .BC(BC), .DI(DI),
    .DO(DO), .DI_RD(DI_RD), .RD_A0(RD_A0), .WR_STB(WR_STB), .WR_CS(WR_CS),
    .WR_A0(WR_A0), .WR_D(WR_D), .FM_ENA(FM_ENA), .CUR_CHIP(CUR_CHIP),
    .BUSY(BUSY), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  int nchecks = 0;
  int nerr = 0;

  // Expected chip writes: {chip[1:0], a0, data[7:0]}
  logic [10:0] exp_q[$];

  // Reference state
  int         m_chip, m_bank;
  logic       m_stat, m_acc, m_ovf;
  logic [1:0] m_fm;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    nchecks++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  function automatic void model_reset();
    m_chip = 0; m_bank = 0; m_stat = 1'b1; m_acc = 1'b0; m_ovf = 1'b0; m_fm = 2'b00;
    exp_q.delete();
  endfunction

  function automatic void model_push(input logic a0, input logic [7:0] d);
    if (!CE && exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else exp_q.push_back({2'(m_chip), a0, d});
  endfunction

  function automatic void model_cmd(input logic bc, input logic [7:0] d);
    int nc;
    if (bc) begin
      if (d >= 8'hF8) begin
        nc = m_bank * 2 + (d[0] ? 0 : 1);
        if (nc < NCHIPS) begin
          m_chip = nc; m_stat = d[1]; m_fm[nc] = ~d[2]; m_acc = 1'b0;
        end
      end else if (d >= 8'hF0 && d <= 8'hF3) begin
        if (NCHIPS > 2) m_bank = d[0];
        m_acc = 1'b0;
      end else begin
        m_acc = (d < 8'h10) || m_fm[m_chip];
        if (m_acc) model_push(1'b0, d);
      end
    end else if (m_acc) begin
      model_push(1'b1, d);
    end
  endfunction

  function automatic void check_state(input string tag);
    logic [7:0] want_do;
    want_do = (m_chip == 0) ? DI_RD[7:0] : DI_RD[15:8];
    check({tag, "_cur_chip"}, 32'(CUR_CHIP), 32'(m_chip));
    check({tag, "_fm_ena"},   32'(FM_ENA),   32'(m_fm));
    check({tag, "_rd_a0"},    32'(RD_A0),    32'(m_stat));
    check({tag, "_do"},       32'(DO),       32'(want_do));
    check({tag, "_busy"},     32'(BUSY),     32'(exp_q.size() != 0));
    check({tag, "_ovf"},      32'(OVF),      32'(m_ovf));
  endfunction

  task automatic host_write(input logic bc, input logic [7:0] d);
    @(negedge CLK);
    BC = bc; DI = d; BDIR = 1'b1; DI_RD = 16'($urandom);
    model_cmd(bc, d);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    BDIR = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge CLK) begin
    logic [10:0] e;
    if (WR_STB === 1'b1) begin
      if (exp_q.size() == 0) begin
        nchecks++; nerr++;
        $display("FAIL unexpected_strobe: got cs=%b a0=%b d=%h expected no strobe", WR_CS, WR_A0, WR_D);
      end else begin
        e = exp_q.pop_front();
        check("wr_cs", 32'(WR_CS), 32'(2'b01 << e[10:9]));
        check("wr_a0", 32'(WR_A0), 32'(e[8]));
        check("wr_d",  32'(WR_D),  32'(e[7:0]));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    check_state("reset");
    check("reset_wr_stb", 32'(WR_STB), 32'd0);

    // Basic register/data pair on chip 0
    host_write(1'b1, 8'h07);
    host_write(1'b0, 8'h3F);
    check_state("basic");

    // FM gating, then enable FM on chip 0
    host_write(1'b1, 8'h28);
    host_write(1'b0, 8'h11);
    check_state("fm_off");
    host_write(1'b1, 8'hFB);
    host_write(1'b1, 8'h28);
    host_write(1'b0, 8'h22);
    check_state("fm_on");

    // Chip 1 selection, bank command ignored with two chips
    host_write(1'b1, 8'hFE);
    host_write(1'b1, 8'h05);
    host_write(1'b0, 8'h44);
    host_write(1'b1, 8'hF1);
    check_state("chip1");

    // Overflow: 9 pushes with CE held low
    CE = 1'b0;
    host_write(1'b1, 8'h01);
    for (int i = 0; i < 8; i++) host_write(1'b0, 8'(8'h80 + i));
    check_state("full");
    CE = 1'b1;
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    check_state("drained");

    // Reset with entries queued and BDIR high through release
    do_reset();
    CE = 1'b0;
    host_write(1'b1, 8'h02);
    host_write(1'b0, 8'h33);
    host_write(1'b0, 8'h34);
    check("pre_reset_busy", 32'(BUSY), 32'd1);
    @(negedge CLK);
    BDIR = 1'b1; BC = 1'b1; DI = 8'h01; CE = 1'b1; RESET_N = 1'b0;
    model_reset();
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check_state("post_reset");
    BDIR = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check_state("post_reset_idle");

    // Randomized traffic with CE high, and occasional CE-low bursts
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 40; k++) begin
        int op;
        op = $urandom_range(0, 9);
        if (op < 2)      host_write(1'b1, 8'(8'hF8 | $urandom_range(0, 7)));
        else if (op < 3) host_write(1'b1, 8'(8'hF0 | $urandom_range(0, 3)));
        else if (op < 6) host_write(1'b1, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom));
        else             host_write(1'b0, 8'($urandom));
      end
      check_state("rand");
      CE = 1'b0;
      host_write(1'b1, 8'h03);
      for (int k = 0; k < int'($urandom_range(4, 10)); k++) host_write(1'b0, 8'($urandom));
      check_state("burst");
      CE = 1'b1;
      repeat (14) @(posedge CLK);
      @(negedge CLK);
      check_state("burst_drain");
    end

    repeat (20) @(posedge CLK);
    @(negedge CLK);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/turbosound_bus.md
TURBOSOUND_BUS -- requirements
Module: turbosound_bus

Interface
REQ-001 SHALL have parameter NCHIPS, default 2, number of attached PSG/FM chips (legal 1..4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, write-queue entries (power of 2, 2..16).
REQ-003 CLK  in  1  single system clock; all state on rising edge.
REQ-004 RESET_N  in  1  reset, synchronous and active-low.
REQ-005 CE  in  1  chip master-clock enable; one queue entry drained per CE cycle.
REQ-006 BDIR  in  1  host bus direction (1 = write), asynchronous.
REQ-007 BC  in  1  host bus control (1 = address/command, 0 = data), asynchronous.
REQ-008 DI  in  8  host data, asynchronous.
REQ-009 DO  out  8  read data, DI_RD byte of the selected chip.
REQ-010 DI_RD  in  8*NCHIPS  chip read buses, chip i at bits [8i+7:8i].
REQ-011 RD_A0  out  1  chip address line for reads (= stat_sel).
REQ-012 WR_STB  out  1  one-CLK chip write strobe.
REQ-013 WR_CS  out  NCHIPS  one-hot chip select, valid with WR_STB.
REQ-014 WR_A0  out  1  0 = address write, 1 = data write.
REQ-015 WR_D  out  8  chip write byte.
REQ-016 FM_ENA  out  NCHIPS  per-chip FM enable.
REQ-017 CUR_CHIP  out  2  currently selected chip index.
REQ-018 BUSY  out  1  queue non-empty.
REQ-019 OVF  out  1  sticky queue overflow flag.

Function
REQ-020 BDIR, BC, DI SHALL pass through a 2-flop synchronizer (no reset); a command fires on the cycle synced BDIR is 1 and was 0 the previous cycle.
REQ-021 Select command (BC=1, DI[7:3]=11111): chip <= {bank, ~DI[0]}, stat_sel <= DI[1], FM_ENA[chip_new] <= ~DI[2], acc <= 0; no queue push.
REQ-022 Bank command (BC=1, DI[7:2]=111100): bank <= DI[0] when NCHIPS>2, else ignored; acc <= 0; no push.
REQ-023 A select resolving to chip >= NCHIPS SHALL be ignored entirely.
REQ-024 Other BC=1 write: acc <= (DI[7:4]==0) | FM_ENA[chip]; if so push {chip, A0=0, DI}.
REQ-025 BC=0 write: push {chip, A0=1, DI} only if acc=1; acc unchanged.
REQ-026 Push SHALL occur on the edge after command detection; entry carries chip index at push time, so later selects do not retarget queued entries.
REQ-027 Drain: on an edge with CE=1 and queue non-empty, pop head and register WR_STB=1, WR_CS=onehot(chip), WR_A0, WR_D for exactly one CLK; WR_STB=0 otherwise (WR_CS/WR_A0/WR_D hold last value).
REQ-028 An entry pushed at edge t SHALL be drainable no earlier than edge t+1; order strictly FIFO.
REQ-029 Simultaneous push and pop when full: both proceed, no overflow.
REQ-030 Push when full without pop: entry dropped, OVF <= 1 until reset.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-032 DO = DI_RD[8*chip +: 8] combinational; RD_A0 = stat_sel.
REQ-033 BUSY = (count != 0).

Reset
REQ-034 While RESET_N=0 at an edge: chip=0, bank=0, stat_sel=1, FM_ENA=0, acc=0, queue empty, OVF=0, WR_STB=0, WR_CS=0, WR_A0=0, WR_D=0.
REQ-035 Edge-detect register SHALL track synced BDIR during reset, so BDIR held high across reset release fires no command.
REQ-036 Reset mid-queue SHALL discard all pending entries; no WR_STB on the reset edge or after it until a new push.

Verification
REQ-037 After reset, CE=1: BC=1 DI=0x07, then BC=0 DI=0x3F -> two strobes, chip 0: (A0=0,D=0x07), then (A0=1,D=0x3F); FM_ENA=00.
REQ-038 FM gating: BC=1 DI=0x28 with FM_ENA[0]=0 -> no push, next data write dropped; after select 0xFB (chip 0, FM on), 0x28 and data are written.
REQ-039 Select 0xFE (chip 1) then reg/data writes, NCHIPS=2 -> WR_CS=10; bank command 0xF1 ignored, CUR_CHIP stays 1.
REQ-040 CE held 0, 9 pushes into FIFO_DEPTH=8 -> BUSY=1, OVF=1; with CE=1, exactly 8 strobes in push order, then BUSY=0.
REQ-041 Reset asserted with 3 entries queued and BDIR held high through release -> no strobes, OVF=0, BUSY=0, no command fires.
